// File: rtl/sync_edge_tracker.sv
// Multi-channel input synchronizer with registered rise/fall/event pulses and sticky pending flags.
// Defining SYNC_DEBOUNCE_EN adds a per-channel debounce filter in front of q.
module sync_edge_tracker #(
    parameter int WIDTH           = 4,
    parameter int STAGES          = 2,
    parameter int EDGE_MODE       = 0,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] clear,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] event_pulse,
    output logic [WIDTH-1:0] event_pending
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_edge_tracker: STAGES must be >= 2");
    end
    if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_edge_mode
        $error("sync_edge_tracker: EDGE_MODE must be 0, 1 or 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("sync_edge_tracker: DEBOUNCE_CYCLES must be >= 1");
    end

    // q is the last flop of the chain, so only STAGES-1 plain stages sit in front of it.
    localparam int SYNC_N = (STAGES < 2) ? 1 : STAGES - 1;

    logic [WIDTH-1:0] sync_q [SYNC_N];
    logic [WIDTH-1:0] sync_last;
    logic [WIDTH-1:0] q_q,    q_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] evt_q,  evt_d;
    logic [WIDTH-1:0] pend_q, pend_d;

    assign sync_last = sync_q[SYNC_N-1];

`ifdef SYNC_DEBOUNCE_EN
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // The counter only runs while the synchronized level disagrees with q and
    // is cleared on the cycle q accepts the new level, so it can never wrap.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        q_d = q_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_last[i] != q_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    q_d[i] = sync_last[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end
`else
    assign q_d = sync_last;
`endif

    always_comb begin
        rise_d = q_d & ~q_q;
        fall_d = ~q_d & q_q;
        if (EDGE_MODE == 0) begin
            evt_d = rise_d;
        end else if (EDGE_MODE == 1) begin
            evt_d = fall_d;
        end else begin
            evt_d = rise_d | fall_d;
        end
        // A new event wins over a clear arriving in the same cycle.
        pend_d = evt_d | (pend_q & ~clear);
    end

    // NOTE: non-blocking assignments let every flop sample the pre-edge value of its neighbour.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the sync chain is reset too, so no edge captured before reset can surface afterwards.
            for (int k = 0; k < SYNC_N; k++) sync_q[k] <= '0;
            q_q    <= '0;
            rise_q <= '0;
            fall_q <= '0;
            evt_q  <= '0;
            pend_q <= '0;
        end else begin
            sync_q[0] <= d;
            for (int k = 1; k < SYNC_N; k++) sync_q[k] <= sync_q[k-1];
            q_q    <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            evt_q  <= evt_d;
            pend_q <= pend_d;
        end
    end

    assign q             = q_q;
    assign rise_pulse    = rise_q;
    assign fall_pulse    = fall_q;
    assign event_pulse   = evt_q;
    assign event_pending = pend_q;

endmodule

// File: doc/sync_edge_tracker.md
Name: sync_edge_tracker

Overview:
Multi-channel input synchronizer with per-channel edge detection and sticky event tracking, for asynchronous inputs such as buttons, UART RX and external strobes.
- Generalises the two-flop metastability flop with rising-edge pulse and the single request-pending latch.
- Adds configurable width, sync depth and edge mode, falling/both-edge pulses, per-channel sticky pending flags with clear, and an optional debounce filter.
- Sits between the pad/IO layer and the peripheral or CPU interrupt logic.

Parameters:
- WIDTH, 4, number of independent channels (>=1).
- STAGES, 2, synchronizer flop depth (>=2; elaboration $error if <2).
- EDGE_MODE, 0, edge type that drives event_pulse and event_pending: 0 = rising, 1 = falling, 2 = both.
- DEBOUNCE_CYCLES, 4, stable cycles required before q changes (>=1). Used only when SYNC_DEBOUNCE_EN is defined.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high reset.
- d, input, WIDTH, asynchronous raw inputs.
- clear, input, WIDTH, per-channel clear of event_pending.
- q, output, WIDTH, synchronized (optionally debounced) level.
- rise_pulse, output, WIDTH, one-cycle pulse when q goes 0->1.
- fall_pulse, output, WIDTH, one-cycle pulse when q goes 1->0.
- event_pulse, output, WIDTH, rise_pulse, fall_pulse or their OR, selected by EDGE_MODE.
- event_pending, output, WIDTH, sticky flag set by event_pulse, held until clear.

Behaviour:
- One clock (clk). reset is synchronous, active-high.
- All outputs are registered.
- Reset: sync chain, q, rise_pulse, fall_pulse, event_pulse, event_pending and debounce counters all go to 0. Reset mid-operation discards any in-flight edge; no pulse is produced for it.
- Sync chain per channel: s[0] <= d[i]; s[k] <= s[k-1] for k = 1..STAGES-2. The final stage is q itself.
- Latency (no debounce): d stable before edge N gives q updated at edge N+STAGES-1. For STAGES=2, q updates at edge N+1.
- Edge detect: at the edge where q[i] takes a new value, rise_pulse[i] (0->1) or fall_pulse[i] (1->0) is set to 1 at that same edge. It is cleared at the next edge unless q changes again; with debounce off, q can toggle every cycle, giving back-to-back alternating pulses. Pulses are high exactly while q has just changed: one cycle per transition.
- event_pulse[i] is registered at the same edge as the rise or fall pulse it selects.
- event_pending[i]:
  - set at the edge where event_pulse[i] is set;
  - cleared at the edge after clear[i]=1 is sampled;
  - simultaneous set and clear: set wins, flag stays 1;
  - clear while not pending: no effect.
- Channels are fully independent; there is no cross-channel interaction.
- d high throughout reset: after reset deasserts, q rises through the normal path and produces rise_pulse (and event_pulse when EDGE_MODE is 0 or 2).
- A glitch on d shorter than one clock period may or may not be captured. It must never produce a pulse wider than one cycle.

Optional Feature:
- Macro: SYNC_DEBOUNCE_EN.
- Defined:
  - Per-channel counter of width $clog2(DEBOUNCE_CYCLES+1) compares the last sync stage s[STAGES-2] with q.
  - While they differ, the counter increments. When it reaches DEBOUNCE_CYCLES-1 and they still differ, q takes the new value at the next edge, the counter resets to 0, and the edge pulses fire.
  - Any cycle where they match resets the counter to 0.
  - Added latency: DEBOUNCE_CYCLES cycles.
  - The counter does not wrap; it saturates by construction.
- Undefined: no counters, q is the plain final sync stage, and DEBOUNCE_CYCLES is ignored.

Test Plan:
1. WIDTH=4, STAGES=2, EDGE_MODE=0, no debounce. d[0] goes 0->1 before edge 10 -> q[0]=1 from edge 11; rise_pulse[0], event_pulse[0] and event_pending[0] =1 at edge 11; pulses return to 0 at edge 12; event_pending[0] stays 1.
2. Same setup, EDGE_MODE=2: d[1] high for 5 cycles, then low -> exactly one rise_pulse[1] and one fall_pulse[1], and 2 event_pulse[1] cycles; other channels stay 0.
3. event_pending[2]=1, then clear[2]=1 in the same cycle as a new event_pulse[2] -> event_pending[2] remains 1. clear[2] alone on the next cycle -> event_pending[2]=0 at the following edge.
4. STAGES=3: d[3] toggles before edge 20 -> q[3] changes at edge 22 and the pulse fires at edge 22.
5. d=4'hF held during reset for 3 cycles, reset released at edge 5 -> q=4'hF at edge 6 (STAGES=2), rise_pulse=4'hF for one cycle. Asserting reset mid-transition clears all outputs at the next edge.
6. SYNC_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: a 3-cycle high pulse on d[0] -> q[0] never changes. d[0] held high -> q[0] rises 4 cycles after the sync stage goes high, with a single rise_pulse[0].
